// File: rtl/keccak_pkg.sv
// keccak_pkg: shared Keccak-p[1600] constants, round-controller state type and first-round helper.
//   MAX_ROUNDS        rounds in a full Keccak-f[1600] permutation
//   ROUND_INDEX_SIZE  width of the round index fed to iota
//   FIRST_ROUND_IDX   first FIPS202 round index for a reduced-round permutation
package keccak_pkg;
    localparam int MAX_ROUNDS       = 24;
    localparam int ROUND_INDEX_SIZE = $clog2(MAX_ROUNDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} keccak_ctrl_state_e;

    function automatic logic [ROUND_INDEX_SIZE-1:0] FIRST_ROUND_IDX(input int nr);
        return ROUND_INDEX_SIZE'(MAX_ROUNDS - nr);
    endfunction
endpackage

// File: rtl/keccak_round_ctrl.sv
// keccak_round_ctrl: sequences one Keccak-p[1600,nr] permutation over a shared round datapath.
//   clk, rst_n                    clock, asynchronous active-low reset
//   start_valid_i/start_ready_o   permutation request handshake from the sponge
//   load_en_o                     state register captures absorbed input (combinational)
//   round_en_o                    state register captures round output (combinational)
//   round_index_o, step_o         current FIPS202 round index and sub-step (registered)
//   busy_o                        permutation in progress (registered)
//   done_valid_o/done_ready_i     result handshake back to the sponge
//   abort_i                       only when KECCAK_CTRL_ABORT_EN is defined: drop to IDLE
module keccak_round_ctrl
    import keccak_pkg::*;
#(
    parameter int  NUM_ROUNDS      = 24,
    parameter int  STEPS_PER_ROUND = 1,
    localparam int STEP_W          = $clog2(STEPS_PER_ROUND) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
`ifdef KECCAK_CTRL_ABORT_EN
    input  logic                        abort_i,
`endif
    input  logic                        start_valid_i,
    output logic                        start_ready_o,
    output logic                        load_en_o,
    output logic                        round_en_o,
    output logic [ROUND_INDEX_SIZE-1:0] round_index_o,
    output logic [STEP_W-1:0]           step_o,
    output logic                        busy_o,
    output logic                        done_valid_o,
    input  logic                        done_ready_i
);
    localparam logic [ROUND_INDEX_SIZE-1:0] FIRST_IDX = FIRST_ROUND_IDX(NUM_ROUNDS);
    localparam logic [ROUND_INDEX_SIZE-1:0] LAST_IDX  = ROUND_INDEX_SIZE'(MAX_ROUNDS - 1);
    localparam logic [STEP_W-1:0]           LAST_STEP = STEP_W'(STEPS_PER_ROUND - 1);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > MAX_ROUNDS || STEPS_PER_ROUND < 1) begin : g_bad_cfg
        $error("keccak_round_ctrl: NUM_ROUNDS must be 1..MAX_ROUNDS and STEPS_PER_ROUND >= 1");
    end

    keccak_ctrl_state_e                state_q, state_d;
    logic [ROUND_INDEX_SIZE-1:0]       round_q, round_d;
    logic [STEP_W-1:0]                 step_q, step_d;
    logic                              busy_q, done_q;
    logic                              abort;

`ifdef KECCAK_CTRL_ABORT_EN
    // abort has no effect while idle
    assign abort = abort_i && (state_q != IDLE);
`else
    assign abort = 1'b0;
`endif

    assign start_ready_o = (state_q == IDLE) || (state_q == DONE && done_ready_i && !abort);
    assign load_en_o     = start_valid_i && start_ready_o;
    assign round_en_o    = (state_q == RUN) && (step_q == LAST_STEP) && !abort;
    assign done_valid_o  = done_q && !abort;
    assign round_index_o = round_q;
    assign step_o        = step_q;
    assign busy_o        = busy_q;

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        step_d  = '0;
        case (state_q)
            IDLE:    state_d = start_valid_i ? RUN : IDLE;
            RUN:     state_d = abort ? IDLE : (round_en_o && round_q == LAST_IDX) ? DONE : RUN;
            DONE:    state_d = abort ? IDLE : done_ready_i ? (start_valid_i ? RUN : IDLE) : DONE;
            default: state_d = IDLE;
        endcase
        // the index saturates at the last round; it only restarts on a new load
        if (load_en_o)
            round_d = FIRST_IDX;
        else if (round_en_o && round_q != LAST_IDX)
            round_d = round_q + 1'b1;
        if (state_q == RUN && !abort && step_q != LAST_STEP)
            step_d = step_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= FIRST_IDX;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            step_q  <= step_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end
endmodule

// File: tb/tb_keccak_round_ctrl.sv
// tb_keccak_round_ctrl: two controllers (24x1 and 12x2) on shared stimulus against a phase-count model.
module tb_keccak_round_ctrl;
    import keccak_pkg::*;

    logic clk = 1'b0, rst_n = 1'b1, sv = 1'b0, dr = 1'b0;
`ifdef KECCAK_CTRL_ABORT_EN
    logic ab = 1'b0;
`endif
    logic sr_a, ld_a, re_a, busy_a, dv_a, sr_b, ld_b, re_b, busy_b, dv_b;
    logic [4:0] idx_a, idx_b;
    logic [0:0] st_a;
    logic [1:0] st_b;
    int vec = 0, errs = 0;
    int ph = 0;

    always #5 clk = ~clk;

    keccak_round_ctrl dut_a (
        .clk(clk), .rst_n(rst_n),
`ifdef KECCAK_CTRL_ABORT_EN
        .abort_i(ab),
`endif
        .start_valid_i(sv), .start_ready_o(sr_a), .load_en_o(ld_a), .round_en_o(re_a),
        .round_index_o(idx_a), .step_o(st_a), .busy_o(busy_a), .done_valid_o(dv_a),
        .done_ready_i(dr)
    );

    keccak_round_ctrl #(.NUM_ROUNDS(12), .STEPS_PER_ROUND(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
`ifdef KECCAK_CTRL_ABORT_EN
        .abort_i(ab),
`endif
        .start_valid_i(sv), .start_ready_o(sr_b), .load_en_o(ld_b), .round_en_o(re_b),
        .round_index_o(idx_b), .step_o(st_b), .busy_o(busy_b), .done_valid_o(dv_b),
        .done_ready_i(dr)
    );

    // Both configurations take 24 cycles of rounds, so one phase count serves both:
    // 0 idle, 1..24 running cycle k after acceptance, 25 result waiting.
    function automatic logic ab_act();
`ifdef KECCAK_CTRL_ABORT_EN
        return ab && ph != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [4:0] exp_ctl(input int s);
        logic a, run, dn, sr;
        a   = ab_act();
        run = ph >= 1 && ph <= 24;
        dn  = ph == 25;
        sr  = (ph == 0) || (dn && dr && !a);
        return {sr, sv && sr && !a, run && ((ph - 1) % s == s - 1) && !a, run, dn && !a};
    endfunction

    function automatic logic [6:0] exp_pos(input int first, input int s);
        logic [4:0] i;
        logic [1:0] st;
        i  = 5'(first + (ph - 1) / s);
        st = 2'((ph - 1) % s);
        return {i, st};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ph <= 0;
        else if (ab_act()) ph <= 0;
        else if (ph == 0) ph <= sv ? 1 : 0;
        else if (ph < 25) ph <= ph + 1;
        else if (dr) ph <= sv ? 1 : 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec++; if ({sr_a, ld_a, re_a, busy_a, dv_a} !== 5'b10000) begin errs++; $display("FAIL reset ctl_a got=%b exp=10000", {sr_a, ld_a, re_a, busy_a, dv_a}); end
        vec++; if ({sr_b, ld_b, re_b, busy_b, dv_b} !== 5'b10000) begin errs++; $display("FAIL reset ctl_b got=%b exp=10000", {sr_b, ld_b, re_b, busy_b, dv_b}); end
        vec++; if (idx_a !== 5'd0) begin errs++; $display("FAIL reset idx_a got=%0d exp=0", idx_a); end
        vec++; if (idx_b !== 5'd12) begin errs++; $display("FAIL reset idx_b got=%0d exp=12", idx_b); end
        vec++; if ({st_a, st_b} !== 3'b000) begin errs++; $display("FAIL reset step got=%b exp=000", {st_a, st_b}); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_defaults();
        int t_done = -1;
        sv = 1'b1;
        dr = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            vec++; if ({sr_a, ld_a, re_a, busy_a, dv_a} !== exp_ctl(1)) begin errs++; $display("FAIL defaults ctl_a ph=%0d got=%b exp=%b", ph, {sr_a, ld_a, re_a, busy_a, dv_a}, exp_ctl(1)); end
            vec++; if ({sr_b, ld_b, re_b, busy_b, dv_b} !== exp_ctl(2)) begin errs++; $display("FAIL defaults ctl_b ph=%0d got=%b exp=%b", ph, {sr_b, ld_b, re_b, busy_b, dv_b}, exp_ctl(2)); end
            if (ph >= 1 && ph <= 24) begin
                vec++; if ({idx_a, 1'b0, st_a} !== exp_pos(0, 1)) begin errs++; $display("FAIL defaults pos_a ph=%0d got=%b exp=%b", ph, {idx_a, 1'b0, st_a}, exp_pos(0, 1)); end
                vec++; if ({idx_b, st_b} !== exp_pos(12, 2)) begin errs++; $display("FAIL defaults pos_b ph=%0d got=%b exp=%b", ph, {idx_b, st_b}, exp_pos(12, 2)); end
            end
            if (dv_a && t_done < 0) t_done = c;
            tick();
            sv = 1'b0;
        end
        vec++; if (t_done != 25) begin errs++; $display("FAIL defaults latency got=%0d exp=25", t_done); end
        dr = 1'b1;
        tick();
        dr = 1'b0;
    endtask

    task automatic test_hold_done();
        sv = 1'b1;
        dr = 1'b0;
        for (int c = 0; c < 40 && !dv_a; c++) begin
            @(negedge clk);
            vec++; if ({sr_a, ld_a, re_a, busy_a, dv_a} !== exp_ctl(1)) begin errs++; $display("FAIL hold ctl_a ph=%0d got=%b exp=%b", ph, {sr_a, ld_a, re_a, busy_a, dv_a}, exp_ctl(1)); end
            vec++; if ({sr_b, ld_b, re_b, busy_b, dv_b} !== exp_ctl(2)) begin errs++; $display("FAIL hold ctl_b ph=%0d got=%b exp=%b", ph, {sr_b, ld_b, re_b, busy_b, dv_b}, exp_ctl(2)); end
            tick();
            sv = 1'b0;
        end
        vec++; if (dv_a !== 1'b1) begin errs++; $display("FAIL hold reach_done got=%b exp=1 (timeout)", dv_a); end
        for (int k = 0; k < 5; k++) begin
            sv = 1'($urandom_range(0, 1));
            @(negedge clk);
            vec++; if ({dv_a, re_a, sr_a, ld_a, dv_b, re_b, sr_b, ld_b} !== 8'b10001000) begin errs++; $display("FAIL hold held k=%0d got=%b exp=10001000", k, {dv_a, re_a, sr_a, ld_a, dv_b, re_b, sr_b, ld_b}); end
            tick();
        end
        sv = 1'b0;
        dr = 1'b1;
        @(negedge clk);
        vec++; if ({sr_a, ld_a, re_a, busy_a, dv_a} !== exp_ctl(1)) begin errs++; $display("FAIL hold release got=%b exp=%b", {sr_a, ld_a, re_a, busy_a, dv_a}, exp_ctl(1)); end
        tick();
        dr = 1'b0;
        @(negedge clk);
        vec++; if ({busy_a, dv_a, sr_a, busy_b, dv_b, sr_b} !== 6'b001001) begin errs++; $display("FAIL hold idle got=%b exp=001001", {busy_a, dv_a, sr_a, busy_b, dv_b, sr_b}); end
        tick();
    endtask

    task automatic test_back_to_back();
        int t;
        sv = 1'b1;
        dr = 1'b0;
        for (int c = 0; c < 40 && !dv_a; c++) begin
            @(negedge clk);
            vec++; if ({sr_a, ld_a, re_a, busy_a, dv_a} !== exp_ctl(1)) begin errs++; $display("FAIL b2b ctl_a ph=%0d got=%b exp=%b", ph, {sr_a, ld_a, re_a, busy_a, dv_a}, exp_ctl(1)); end
            tick();
            sv = 1'b0;
        end
        sv = 1'b1;
        dr = 1'b1;
        @(negedge clk);
        vec++; if ({ld_a, ld_b, sr_a, dv_a} !== 4'b1111) begin errs++; $display("FAIL b2b load got=%b exp=1111", {ld_a, ld_b, sr_a, dv_a}); end
        tick();
        sv = 1'b0;
        dr = 1'b0;
        for (t = 1; t < 40 && !dv_a; t++) begin
            @(negedge clk);
            if (t == 1) begin
                vec++; if ({busy_a, idx_a, idx_b} !== {1'b1, 5'd0, 5'd12}) begin errs++; $display("FAIL b2b first_idx got=%b/%0d/%0d exp=1/0/12", busy_a, idx_a, idx_b); end
            end
            vec++; if ({sr_b, ld_b, re_b, busy_b, dv_b} !== exp_ctl(2)) begin errs++; $display("FAIL b2b ctl_b ph=%0d got=%b exp=%b", ph, {sr_b, ld_b, re_b, busy_b, dv_b}, exp_ctl(2)); end
            if (ph >= 1 && ph <= 24) begin
                vec++; if ({idx_b, st_b} !== exp_pos(12, 2)) begin errs++; $display("FAIL b2b pos_b ph=%0d got=%b exp=%b", ph, {idx_b, st_b}, exp_pos(12, 2)); end
            end
            tick();
        end
        vec++; if (t != 25) begin errs++; $display("FAIL b2b latency got=%0d exp=25", t); end
        dr = 1'b1;
        tick();
        dr = 1'b0;
    endtask

    task automatic test_async_reset();
        int t;
        sv = 1'b1;
        dr = 1'b0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            vec++; if ({sr_a, ld_a, re_a, busy_a, dv_a} !== exp_ctl(1)) begin errs++; $display("FAIL areset ctl_a ph=%0d got=%b exp=%b", ph, {sr_a, ld_a, re_a, busy_a, dv_a}, exp_ctl(1)); end
            tick();
            sv = 1'b0;
        end
        @(negedge clk);
        vec++; if (idx_a !== 5'd10) begin errs++; $display("FAIL areset pre_idx got=%0d exp=10", idx_a); end
        rst_n = 1'b0;
        #1;
        vec++; if ({sr_a, ld_a, re_a, busy_a, dv_a, idx_a} !== {5'b10000, 5'd0}) begin errs++; $display("FAIL areset now_a got=%b exp=%b", {sr_a, ld_a, re_a, busy_a, dv_a, idx_a}, {5'b10000, 5'd0}); end
        vec++; if ({sr_b, ld_b, re_b, busy_b, dv_b, idx_b, st_b} !== {5'b10000, 5'd12, 2'd0}) begin errs++; $display("FAIL areset now_b got=%b exp=%b", {sr_b, ld_b, re_b, busy_b, dv_b, idx_b, st_b}, {5'b10000, 5'd12, 2'd0}); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        sv = 1'b1;
        for (t = 0; t < 40 && !dv_a; t++) begin
            @(negedge clk);
            vec++; if ({sr_a, ld_a, re_a, busy_a, dv_a} !== exp_ctl(1)) begin errs++; $display("FAIL areset rerun_a ph=%0d got=%b exp=%b", ph, {sr_a, ld_a, re_a, busy_a, dv_a}, exp_ctl(1)); end
            tick();
            sv = 1'b0;
        end
        vec++; if (t != 25) begin errs++; $display("FAIL areset rerun_latency got=%0d exp=25", t); end
        dr = 1'b1;
        tick();
        dr = 1'b0;
    endtask

`ifdef KECCAK_CTRL_ABORT_EN
    task automatic test_abort();
        sv = 1'b1;
        dr = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            sv = 1'b0;
        end
        ab = 1'b1;
        @(negedge clk);
        vec++; if ({re_a, re_b, idx_a} !== {2'b00, 5'd5}) begin errs++; $display("FAIL abort run got=%b exp=%b", {re_a, re_b, idx_a}, {2'b00, 5'd5}); end
        tick();
        ab = 1'b0;
        @(negedge clk);
        vec++; if ({busy_a, dv_a, sr_a, busy_b, dv_b, sr_b} !== 6'b001001) begin errs++; $display("FAIL abort run_idle got=%b exp=001001", {busy_a, dv_a, sr_a, busy_b, dv_b, sr_b}); end
        tick();
        sv = 1'b1;
        for (int c = 0; c < 40 && !dv_a; c++) begin
            tick();
            sv = 1'b0;
        end
        sv = 1'b1;
        dr = 1'b1;
        ab = 1'b1;
        @(negedge clk);
        vec++; if ({ld_a, ld_b, dv_a, dv_b, re_a, re_b} !== 6'b000000) begin errs++; $display("FAIL abort done got=%b exp=000000", {ld_a, ld_b, dv_a, dv_b, re_a, re_b}); end
        tick();
        sv = 1'b0;
        dr = 1'b0;
        ab = 1'b0;
        @(negedge clk);
        vec++; if ({busy_a, dv_a, sr_a, busy_b, dv_b, sr_b} !== 6'b001001) begin errs++; $display("FAIL abort done_idle got=%b exp=001001", {busy_a, dv_a, sr_a, busy_b, dv_b, sr_b}); end
        tick();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            sv = 1'($urandom_range(0, 1));
            dr = ($urandom_range(0, 3) != 0);
`ifdef KECCAK_CTRL_ABORT_EN
            ab = ($urandom_range(0, 31) == 0);
`endif
            @(negedge clk);
            vec++; if ({sr_a, ld_a, re_a, busy_a, dv_a} !== exp_ctl(1)) begin errs++; $display("FAIL random ctl_a ph=%0d got=%b exp=%b", ph, {sr_a, ld_a, re_a, busy_a, dv_a}, exp_ctl(1)); end
            vec++; if ({sr_b, ld_b, re_b, busy_b, dv_b} !== exp_ctl(2)) begin errs++; $display("FAIL random ctl_b ph=%0d got=%b exp=%b", ph, {sr_b, ld_b, re_b, busy_b, dv_b}, exp_ctl(2)); end
            if (ph >= 1 && ph <= 24) begin
                vec++; if ({idx_a, 1'b0, st_a} !== exp_pos(0, 1)) begin errs++; $display("FAIL random pos_a ph=%0d got=%b exp=%b", ph, {idx_a, 1'b0, st_a}, exp_pos(0, 1)); end
                vec++; if ({idx_b, st_b} !== exp_pos(12, 2)) begin errs++; $display("FAIL random pos_b ph=%0d got=%b exp=%b", ph, {idx_b, st_b}, exp_pos(12, 2)); end
            end
            tick();
        end
        sv = 1'b0;
        dr = 1'b0;
`ifdef KECCAK_CTRL_ABORT_EN
        ab = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_hold_done();
        test_back_to_back();
        test_async_reset();
`ifdef KECCAK_CTRL_ABORT_EN
        test_abort();
`else
        $display("abort_i absent in this build; abort scenarios skipped");
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
